// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM slave front end: address map,
// response codes, FSM states and decoded region identifiers.
package avalon_pkg;

  localparam int NUM_PIXELS  = 784;
  localparam int NUM_OUTPUTS = 10;

  // Word address map (11-bit word addresses).
  localparam logic [10:0] CTRL_ADDR    = 11'h000;
  localparam logic [10:0] SCRATCH_ADDR = 11'h001;
  localparam logic [10:0] RESULT_BASE  = 11'h010;
  localparam logic [10:0] RESULT_LAST  = RESULT_BASE + 11'(NUM_OUTPUTS - 1);
  localparam logic [10:0] WEIGHT_BASE  = 11'h080;
  localparam logic [10:0] WEIGHT_LAST  = WEIGHT_BASE + 11'(NUM_PIXELS - 1);
  localparam logic [10:0] PIXEL_BASE   = 11'h400;
  localparam logic [10:0] PIXEL_LAST   = PIXEL_BASE + 11'(NUM_PIXELS - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    REG_NONE    = 3'd0,
    REG_CTRL    = 3'd1,
    REG_SCRATCH = 3'd2,
    REG_RESULT  = 3'd3,
    REG_WEIGHT  = 3'd4,
    REG_PIXEL   = 3'd5
  } region_t;

endpackage

// File: rtl/avalon_addr_decode.sv
// Address decoder: maps a word address to its region, the index within that
// region, and whether the access direction is permitted there.
module avalon_addr_decode
  import avalon_pkg::*;
(
  input  logic [10:0] address,
  input  logic        is_write,
  output region_t     region,
  output logic [9:0]  offset,
  output logic        legal
);

  // Region select and region-relative index.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    region = REG_NONE;
    offset = '0;
    if (address == CTRL_ADDR) begin
      region = REG_CTRL;
    end else if (address == SCRATCH_ADDR) begin
      region = REG_SCRATCH;
    end else if (address >= RESULT_BASE && address <= RESULT_LAST) begin
      region = REG_RESULT;
      offset = 10'(address - RESULT_BASE);
    end else if (address >= WEIGHT_BASE && address <= WEIGHT_LAST) begin
      region = REG_WEIGHT;
      offset = 10'(address - WEIGHT_BASE);
    end else if (address >= PIXEL_BASE && address <= PIXEL_LAST) begin
      region = REG_PIXEL;
      offset = 10'(address - PIXEL_BASE);
    end
  end

  // Direction rules: results are read-only, weight/pixel memories write-only.
  always_comb begin
    legal = 1'b0;
    case (region)
      REG_CTRL, REG_SCRATCH: legal = 1'b1;
      REG_RESULT:            legal = !is_write;
      REG_WEIGHT, REG_PIXEL: legal = is_write;
      default:               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/avalon_interface.sv
// Avalon-MM slave front end of the classifier accelerator. Decodes host
// reads/writes into weight/pixel write strobes, CTRL/SCRATCH registers and
// result readback. Single transfers take IDLE -> WAIT -> RESP.
// Build option: define AVALON_BURST_EN to add write-burst support (BURST state).
module avalon_interface
  import avalon_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        write,
  input  logic        read,
  input  logic        beginbursttransfer,
  input  logic [9:0]  burstcount,
  input  logic [10:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] result_output,
  input  logic        done_calc,
  output logic [9:0]  weight_address,
  output logic [9:0]  pixel_address,
  output logic        w_enable_weights,
  output logic        w_enable_pixels,
  output logic        readdatavalid,
  output logic        writeresponsevalid,
  output logic [15:0] store_data,
  output logic [3:0]  output_address,
  output logic        waitrequest,
  output logic [1:0]  response
);

  state_t      state_q, state_d;
  logic        op_rd_q, op_rd_d;
  logic        op_wr_q, op_wr_d;
  logic        done_q, done_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;
  logic        wrv_q, wrv_d;
  logic [1:0]  response_q, response_d;
  logic        wen_w_q, wen_w_d;
  logic        wen_p_q, wen_p_d;
  logic [9:0]  weight_address_q, weight_address_d;
  logic [9:0]  pixel_address_q, pixel_address_d;
  logic [15:0] store_data_q, store_data_d;
  logic [3:0]  output_address_q, output_address_d;

  logic        ctrl_clr;
  logic        mem_wr;
  logic        single_req;

  logic [10:0] dec_addr;
  logic        dec_is_write;
  region_t     dec_region;
  logic [9:0]  dec_offset;
  logic        dec_legal;

`ifdef AVALON_BURST_EN
  logic [10:0] burst_addr_q, burst_addr_d;
  logic        burst_ovf_q, burst_ovf_d;
  logic        burst_err_q, burst_err_d;
  logic        burst_bad_len_q, burst_bad_len_d;
  logic [9:0]  beats_left_q, beats_left_d;
  logic        burst_start;
  logic        burst_beat;
  logic        beat_bad_len;
  logic        beat_ovf;
  logic        beat_ok;
  logic [9:0]  beats_after;
  logic [11:0] next_addr;

  // Later burst beats decode the internally tracked beat address.
  assign dec_addr   = (state_q == S_BURST) ? burst_addr_q : address;
  assign single_req = (read || write) && !burst_start;
`else
  logic unused_burst_inputs;

  // Burst qualifiers have no effect in the single-beat build.
  assign unused_burst_inputs = ^{beginbursttransfer, burstcount};
  assign dec_addr            = address;
  assign single_req          = read || write;
`endif

  // In WAIT the direction comes from the request latched in IDLE.
  assign dec_is_write = (state_q == S_WAIT) ? op_wr_q : write;

  avalon_addr_decode u_decode (
    .address  (dec_addr),
    .is_write (dec_is_write),
    .region   (dec_region),
    .offset   (dec_offset),
    .legal    (dec_legal)
  );

`ifdef AVALON_BURST_EN
  // Qualify the current burst beat: first beat in IDLE, later beats in BURST.
  always_comb begin
    burst_start  = (state_q == S_IDLE) && write && !read && beginbursttransfer;
    burst_beat   = burst_start || ((state_q == S_BURST) && write);
    beat_bad_len = burst_start ? ((burstcount == '0) || (burstcount > 10'(NUM_PIXELS)))
                               : burst_bad_len_q;
    beat_ovf     = burst_start ? 1'b0 : burst_ovf_q;
    beat_ok      = dec_legal && !beat_bad_len && !beat_ovf &&
                   ((dec_region == REG_WEIGHT) || (dec_region == REG_PIXEL));
    next_addr    = {1'b0, dec_addr} + 12'd1;
    if (burst_start) begin
      // A zero burstcount is handled as a single (erroring) beat.
      beats_after = (burstcount == '0) ? '0 : burstcount - 10'd1;
    end else begin
      beats_after = beats_left_q - 10'd1;
    end
  end
`endif

  // Next-state, side effects and registered-output values.
  always_comb begin
    state_d          = state_q;
    op_rd_d          = op_rd_q;
    op_wr_d          = op_wr_q;
    scratch_d        = scratch_q;
    readdata_d       = readdata_q;
    rdv_d            = 1'b0;
    wrv_d            = 1'b0;
    response_d       = response_q;
    wen_w_d          = 1'b0;
    wen_p_d          = 1'b0;
    weight_address_d = weight_address_q;
    pixel_address_d  = pixel_address_q;
    store_data_d     = store_data_q;
    output_address_d = output_address_q;
    waitrequest      = 1'b0;
    ctrl_clr         = 1'b0;
    mem_wr           = 1'b0;
`ifdef AVALON_BURST_EN
    burst_addr_d     = burst_addr_q;
    burst_ovf_d      = burst_ovf_q;
    burst_err_d      = burst_err_q;
    burst_bad_len_d  = burst_bad_len_q;
    beats_left_d     = beats_left_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (single_req) begin
          waitrequest = 1'b1;
          op_rd_d     = read;
          op_wr_d     = write;
          // Present the result index now so the bank answers during WAIT.
          if (read && !write && (dec_region == REG_RESULT)) begin
            output_address_d = dec_offset[3:0];
          end
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        state_d = S_RESP;
        if (op_wr_q) begin
          wrv_d = 1'b1;
          if (op_rd_q || !dec_legal) begin
            response_d = RESP_SLVERR;
          end else begin
            response_d = RESP_OKAY;
            case (dec_region)
              REG_CTRL:              ctrl_clr  = writedata[0];
              REG_SCRATCH:           scratch_d = writedata;
              REG_WEIGHT, REG_PIXEL: mem_wr    = 1'b1;
              default:               ;
            endcase
          end
        end else begin
          rdv_d = 1'b1;
          if (!dec_legal) begin
            response_d = RESP_SLVERR;
            readdata_d = '0;
          end else begin
            response_d = RESP_OKAY;
            case (dec_region)
              REG_CTRL:    readdata_d = {31'b0, done_q};
              REG_SCRATCH: readdata_d = scratch_q;
              REG_RESULT:  readdata_d = result_output;
              default:     readdata_d = '0;
            endcase
          end
        end
      end

      S_RESP: begin
        // Hold off a back-to-back request until IDLE can register it.
        waitrequest = read || write;
        state_d     = S_IDLE;
      end

      default: begin
        // S_BURST: stay until the final beat is seen below.
        state_d = state_q;
      end
    endcase

`ifdef AVALON_BURST_EN
    if (burst_beat) begin
      mem_wr          = beat_ok;
      burst_addr_d    = next_addr[10:0];
      burst_ovf_d     = beat_ovf | next_addr[11];
      burst_bad_len_d = beat_bad_len;
      burst_err_d     = (burst_start ? 1'b0 : burst_err_q) | !beat_ok;
      beats_left_d    = beats_after;
      if (beats_after == '0) begin
        state_d    = S_RESP;
        wrv_d      = 1'b1;
        response_d = burst_err_d ? RESP_SLVERR : RESP_OKAY;
      end else begin
        state_d = S_BURST;
      end
    end
`endif

    if (mem_wr) begin
      store_data_d = writedata[15:0];
      if (dec_region == REG_WEIGHT) begin
        wen_w_d          = 1'b1;
        weight_address_d = dec_offset;
      end else begin
        wen_p_d         = 1'b1;
        pixel_address_d = dec_offset;
      end
    end

    // Sticky done flag: a completion pulse wins over a same-cycle clear.
    done_d = done_calc | (done_q & ~ctrl_clr);
  end

  // State and registered outputs; synchronous reset aborts any transfer.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q          <= S_IDLE;
      op_rd_q          <= 1'b0;
      op_wr_q          <= 1'b0;
      done_q           <= 1'b0;
      scratch_q        <= '0;
      readdata_q       <= '0;
      rdv_q            <= 1'b0;
      wrv_q            <= 1'b0;
      response_q       <= RESP_OKAY;
      wen_w_q          <= 1'b0;
      wen_p_q          <= 1'b0;
      weight_address_q <= '0;
      pixel_address_q  <= '0;
      store_data_q     <= '0;
      output_address_q <= '0;
`ifdef AVALON_BURST_EN
      burst_addr_q     <= '0;
      burst_ovf_q      <= 1'b0;
      burst_err_q      <= 1'b0;
      burst_bad_len_q  <= 1'b0;
      beats_left_q     <= '0;
`endif
    end else begin
      state_q          <= state_d;
      op_rd_q          <= op_rd_d;
      op_wr_q          <= op_wr_d;
      done_q           <= done_d;
      scratch_q        <= scratch_d;
      readdata_q       <= readdata_d;
      rdv_q            <= rdv_d;
      wrv_q            <= wrv_d;
      response_q       <= response_d;
      wen_w_q          <= wen_w_d;
      wen_p_q          <= wen_p_d;
      weight_address_q <= weight_address_d;
      pixel_address_q  <= pixel_address_d;
      store_data_q     <= store_data_d;
      output_address_q <= output_address_d;
`ifdef AVALON_BURST_EN
      burst_addr_q     <= burst_addr_d;
      burst_ovf_q      <= burst_ovf_d;
      burst_err_q      <= burst_err_d;
      burst_bad_len_q  <= burst_bad_len_d;
      beats_left_q     <= beats_left_d;
`endif
    end
  end

  assign readdata           = readdata_q;
  assign readdatavalid      = rdv_q;
  assign writeresponsevalid = wrv_q;
  assign response           = response_q;
  assign w_enable_weights   = wen_w_q;
  assign w_enable_pixels    = wen_p_q;
  assign weight_address     = weight_address_q;
  assign pixel_address      = pixel_address_q;
  assign store_data         = store_data_q;
  assign output_address     = output_address_q;

endmodule

// File: tb/tb_avalon_interface.sv
// Self-checking bench for avalon_interface: directed cases from the register
// map plus randomized transfers compared against a register-map model.
module tb_avalon_interface;

  localparam int K_NONE = 0;
  localparam int K_CTRL = 1;
  localparam int K_SCR  = 2;
  localparam int K_RES  = 3;
  localparam int K_WGT  = 4;
  localparam int K_PIX  = 5;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        write;
  logic        read;
  logic        beginbursttransfer;
  logic [9:0]  burstcount;
  logic [10:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] result_output;
  logic        done_calc;
  logic [9:0]  weight_address;
  logic [9:0]  pixel_address;
  logic        w_enable_weights;
  logic        w_enable_pixels;
  logic        readdatavalid;
  logic        writeresponsevalid;
  logic [15:0] store_data;
  logic [3:0]  output_address;
  logic        waitrequest;
  logic [1:0]  response;

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  // Reference model state.
  logic [31:0] m_scratch;
  logic        m_done;
  logic [31:0] result_mem [16];

  always #5 clk = ~clk;

  // Result bank: returns the word at whatever index the DUT presents.
  assign result_output = result_mem[output_address];

  avalon_interface dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .write              (write),
    .read               (read),
    .beginbursttransfer (beginbursttransfer),
    .burstcount         (burstcount),
    .address            (address),
    .writedata          (writedata),
    .readdata           (readdata),
    .result_output      (result_output),
    .done_calc          (done_calc),
    .weight_address     (weight_address),
    .pixel_address      (pixel_address),
    .w_enable_weights   (w_enable_weights),
    .w_enable_pixels    (w_enable_pixels),
    .readdatavalid      (readdatavalid),
    .writeresponsevalid (writeresponsevalid),
    .store_data         (store_data),
    .output_address     (output_address),
    .waitrequest        (waitrequest),
    .response           (response)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input int a);
    if (a == 0)                           return K_CTRL;
    if (a == 1)                           return K_SCR;
    if (a >= 16 && a < 16 + 10)           return K_RES;
    if (a >= 128 && a < 128 + 784)        return K_WGT;
    if (a >= 1024 && a < 1024 + 784)      return K_PIX;
    return K_NONE;
  endfunction

  function automatic int index_of(input int a);
    case (kind_of(a))
      K_RES:   return a - 16;
      K_WGT:   return a - 128;
      K_PIX:   return a - 1024;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = '0;
    m_done    = 1'b0;
  endtask

  task automatic pulse_done();
    done_calc = 1'b1;
    @(posedge clk); #1;
    done_calc = 1'b0;
    m_done    = 1'b1;
  endtask

  // One single-beat transfer with cycle-accurate handshake checks.
  task automatic xfer(input logic rd, input logic wr, input logic [10:0] a,
                      input logic [31:0] d, input logic done_in_wait);
    int          k;
    logic        exp_err;
    logic        exp_ws;
    logic        exp_ps;
    logic [31:0] exp_rd;
    k = kind_of(int'(a));
    if (wr) exp_err = rd || !(k == K_CTRL || k == K_SCR || k == K_WGT || k == K_PIX);
    else    exp_err = !(k == K_CTRL || k == K_SCR || k == K_RES);
    exp_ws = wr && !exp_err && (k == K_WGT);
    exp_ps = wr && !exp_err && (k == K_PIX);
    case (k)
      K_CTRL:  exp_rd = {31'b0, m_done};
      K_SCR:   exp_rd = m_scratch;
      K_RES:   exp_rd = result_mem[index_of(int'(a))];
      default: exp_rd = '0;
    endcase

    address = a; writedata = d; read = rd; write = wr;
    #1;
    check("request_waitrequest", waitrequest, 1);
    @(posedge clk); #1;
    check("accept_waitrequest", waitrequest, 0);
    check("accept_no_pulse", {readdatavalid, writeresponsevalid}, 0);
    done_calc = done_in_wait;
    @(posedge clk); #1;
    done_calc = 1'b0; read = 1'b0; write = 1'b0;
    #1;
    check("wr_resp_valid", writeresponsevalid, wr);
    check("rd_data_valid", readdatavalid, !wr);
    check("response", response, exp_err ? 2'b10 : 2'b00);
    check("weight_strobe", w_enable_weights, exp_ws);
    check("pixel_strobe", w_enable_pixels, exp_ps);
    if (exp_ws) check("weight_address", weight_address, index_of(int'(a)));
    if (exp_ps) check("pixel_address", pixel_address, index_of(int'(a)));
    if (exp_ws || exp_ps) check("store_data", store_data, d[15:0]);
    if (!wr && !exp_err) check("readdata", readdata, exp_rd);
    if (!wr && !exp_err && k == K_RES) check("output_address", output_address, index_of(int'(a)));
    @(posedge clk); #1;
    check("pulses_cleared",
          {readdatavalid, writeresponsevalid, w_enable_weights, w_enable_pixels}, 0);

    if (wr && !exp_err) begin
      if (k == K_CTRL && d[0]) m_done = 1'b0;
      if (k == K_SCR) m_scratch = d;
    end
    if (done_in_wait) m_done = 1'b1;
  endtask

`ifdef AVALON_BURST_EN
  // Back-to-back write burst; address is held at the base for all beats.
  task automatic burst_write(input logic [10:0] base, input logic [9:0] cnt);
    int   len;
    logic bad_len;
    logic err;
    len     = (cnt == 0) ? 1 : int'(cnt);
    bad_len = (cnt == 0) || (cnt > 10'd784);
    err     = bad_len;
    for (int i = 0; i < len; i++) begin
      int          ba;
      int          k;
      logic        ok;
      logic [31:0] d;
      ba = int'(base) + i;
      k  = (ba > 2047) ? K_NONE : kind_of(ba);
      ok = !bad_len && (k == K_WGT || k == K_PIX);
      if (!ok) err = 1'b1;
      d = $urandom;
      address = base; burstcount = cnt; writedata = d;
      beginbursttransfer = (i == 0); write = 1'b1;
      #1;
      check("burst_waitrequest", waitrequest, 0);
      @(posedge clk); #1;
      write = 1'b0; beginbursttransfer = 1'b0;
      check("burst_weight_strobe", w_enable_weights, ok && k == K_WGT);
      check("burst_pixel_strobe", w_enable_pixels, ok && k == K_PIX);
      if (ok && k == K_WGT) check("burst_weight_address", weight_address, index_of(ba));
      if (ok && k == K_PIX) check("burst_pixel_address", pixel_address, index_of(ba));
      if (ok) check("burst_store_data", store_data, d[15:0]);
      check("burst_resp_valid", writeresponsevalid, i == len - 1);
      if (i == len - 1) check("burst_response", response, err ? 2'b10 : 2'b00);
    end
    @(posedge clk); #1;
    check("burst_pulses_cleared",
          {writeresponsevalid, w_enable_weights, w_enable_pixels}, 0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; write = 1'b0; read = 1'b0; beginbursttransfer = 1'b0;
    burstcount = '0; address = '0; writedata = '0; done_calc = 1'b0;
    for (int i = 0; i < 16; i++) result_mem[i] = $urandom;
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 0);
    check("rst_pulses", {readdatavalid, writeresponsevalid, w_enable_weights, w_enable_pixels}, 0);
    check("rst_addresses", {weight_address, pixel_address, output_address}, 0);
    check("rst_store_data", store_data, 0);
    check("rst_waitrequest", waitrequest, 0);
    check("rst_response", response, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Register-map directed cases.
    xfer(0, 1, 11'h001, 32'hF0F0_F0F0, 0);
    xfer(1, 0, 11'h001, 32'h0, 0);
    xfer(0, 1, 11'h405, 32'h0000_ABCD, 0);
    pulse_done();
    xfer(1, 0, 11'h000, 32'h0, 0);
    xfer(0, 1, 11'h000, 32'h1, 0);
    xfer(1, 0, 11'h000, 32'h0, 0);
    xfer(0, 1, 11'h000, 32'h1, 1);   // set and clear in the same cycle
    xfer(1, 0, 11'h000, 32'h0, 0);
    xfer(1, 0, 11'h013, 32'h0, 0);
    xfer(0, 1, 11'h7FF, 32'h1234_5678, 0);

    // Region boundaries and illegal directions.
    xfer(0, 1, 11'h080, 32'h0000_1111, 0);
    xfer(0, 1, 11'h38F, 32'h0000_2222, 0);
    xfer(0, 1, 11'h390, 32'h0000_3333, 0);
    xfer(0, 1, 11'h70F, 32'h0000_4444, 0);
    xfer(0, 1, 11'h710, 32'h0000_5555, 0);
    xfer(1, 0, 11'h010, 32'h0, 0);
    xfer(1, 0, 11'h019, 32'h0, 0);
    xfer(1, 0, 11'h01A, 32'h0, 0);
    xfer(0, 1, 11'h012, 32'hDEAD_BEEF, 0);
    xfer(1, 0, 11'h200, 32'h0, 0);
    xfer(1, 1, 11'h001, 32'h5555_AAAA, 0);
    xfer(1, 0, 11'h001, 32'h0, 0);

    // Reset during the accept cycle aborts with no response pulse.
    address = 11'h001; writedata = 32'h1357_9BDF; write = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
    model_reset();
    check("abort_no_response", {writeresponsevalid, readdatavalid}, 0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("abort_still_quiet", {writeresponsevalid, readdatavalid}, 0);
    xfer(1, 0, 11'h001, 32'h0, 0);

    // Randomized transfers against the model.
    for (int n = 0; n < 60; n++) begin
      logic [10:0] a;
      logic        rd;
      logic        wr;
      int          op;
      case ($urandom_range(0, 5))
        0:       a = 11'h000;
        1:       a = 11'h001;
        2:       a = 11'(16 + $urandom_range(0, 9));
        3:       a = 11'(128 + $urandom_range(0, 783));
        4:       a = 11'(1024 + $urandom_range(0, 783));
        default: a = 11'($urandom_range(0, 2047));
      endcase
      op = $urandom_range(0, 5);
      wr = (op <= 2) || (op == 5);
      rd = (op >= 3);
      if ($urandom_range(0, 3) == 0) pulse_done();
      xfer(rd, wr, a, $urandom, 1'b0);
    end

`ifdef AVALON_BURST_EN
    burst_write(11'h080, 10'd784);
    burst_write(11'h38E, 10'd3);
    burst_write(11'h400, 10'd0);
    burst_write(11'h402, 10'd4);

    // Reset in the middle of a burst: no response, FSM back to IDLE.
    for (int i = 0; i < 6; i++) begin
      address = 11'h400; burstcount = 10'd20; writedata = $urandom;
      beginbursttransfer = (i == 0); write = 1'b1;
      @(posedge clk); #1;
      check("midburst_no_response", writeresponsevalid, 0);
    end
    beginbursttransfer = 1'b0;
    n_rst = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
    model_reset();
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("postreset_no_response", {writeresponsevalid, w_enable_pixels}, 0);
      @(posedge clk); #1;
    end
    xfer(1, 0, 11'h001, 32'h0, 0);
    xfer(0, 1, 11'h0A0, 32'h0000_7777, 0);
`else
    // Burst qualifiers are ignored: a single beat results.
    beginbursttransfer = 1'b1; burstcount = 10'd5;
    xfer(0, 1, 11'h081, 32'h0000_6666, 0);
    beginbursttransfer = 1'b0; burstcount = '0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
